i2c_cfg_target: RTL and testbench
=================================

Name: i2c_cfg_target

Overview:
- I2C target (responder) that models the HDMI transmitter's configuration port. It is the far end of the init sequencer's (dev_id, reg_id, data) write triples.
- Oversamples SCL/SDA on the 50 MHz reference clock and decodes START, STOP, address, register pointer and data bytes.
- Stores written bytes in an internal 256x8 register file, supports readback, and reports every committed write on a strobe port for checking/logging.

Parameters:
- DEV_ADDR, 7'h39, 7-bit target address (8-bit write form 0x72).
- REG_RESET, 8'h00, reset value of every register-file entry.

Ports:
- clk_ref  in  1  50 MHz reference clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  I2C clock as seen on the bus (asynchronous).
- sda_in  in  1  I2C data as seen on the bus (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- wr_valid  out  1  one-cycle pulse per committed data byte.
- wr_reg  out  8  register index of the committed byte.
- wr_data  out  8  committed byte.
- busy  out  1  high from START to STOP while addressed.
- dbg_reg  in  8  register-file inspection index.
- dbg_data  out  8  regs[dbg_reg], registered, 1-cycle latency.

Behaviour:
- Input sync: scl_in and sda_in each pass through 2 FFs. Edges are detected against a third (previous) stage. All decisions use the synced values. Requires clk_ref >= 20x SCL frequency.
- Bus events:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Data bits are sampled on SCL rising, MSB first.
  - sda_oe changes only on SCL falling, except on reset or STOP.
- Reset: state IDLE; sda_oe=0, wr_valid=0, wr_reg=0, wr_data=0, busy=0, dbg_data=REG_RESET. Pointer=0, bit counter=0, all regs=REG_RESET. Reset mid-transfer releases SDA on the next clk_ref edge.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START in any state goes to ADDR and clears the bit counter (this covers repeated start). STOP in any state goes to IDLE with sda_oe=0 and busy=0; the pointer is retained.
- ADDR: shift 8 bits.
  - bits[7:1]==DEV_ADDR: go to ADDR_ACK, busy=1.
  - Otherwise: go to IGNORE with sda_oe held 0.
- ACK timing (all *_ACK states): sda_oe=1 from the SCL falling edge after bit 8 until the SCL falling edge after bit 9.
- ADDR_ACK exit:
  - R/W=0: go to REG.
  - R/W=1: go to RDATA and load shifter with regs[pointer].
- REG: 8 bits go to the pointer; then REG_ACK, then WDATA.
- WDATA: on the SCL falling edge after bit 8:
  - regs[pointer] <= byte; wr_valid pulses 1 cycle with wr_reg=pointer and wr_data=byte.
  - pointer <= pointer+1 with 8-bit wrap (0xFF to 0x00).
  - Then WDATA_ACK, then WDATA.
- RDATA: on each SCL falling edge drive sda_oe = ~current bit. After 8 bits release SDA and go to RDATA_ACK.
- RDATA_ACK: sample master bit on SCL rising.
  - 0 (ACK): pointer+1 (wrap), load next byte, return to RDATA.
  - 1 (NACK): go to IGNORE; the pointer still increments.
- IGNORE: sda_oe=0; wait for START/STOP.
- STOP or START mid-byte: the partial byte is discarded, with no wr_valid and no register update.
- A byte is committed only when all 8 bits have been sampled. An ACK is never driven for a non-matching address.
- Simultaneous wr_valid commit and a dbg_reg read of the same index: dbg_data returns the old value that cycle and the new value the next cycle.

Test Plan:
- Reset, then write 0x72, 0x41, 0x10, STOP -> ACK low on all 3 bytes; exactly one wr_valid with wr_reg=0x41, wr_data=0x10; dbg_reg=0x41 gives 0x10.
- Write 0x72, 0x98, 0x03, 0xE0, STOP -> two wr_valid pulses: (0x98,0x03), then (0x99,0xE0).
- Write 0x70, 0x41, 0x55 -> sda_oe never asserts, no wr_valid, busy stays 0, regs unchanged.
- After the first scenario: 0x72, 0x41, repeated START, 0x73, read 2 bytes (ACK then NACK), STOP -> SDA carries 0x10 then regs[0x42]=0x00; SDA released after NACK.
- 0x72, 0xFF, 0xAA, 0xBB -> writes to 0xFF then 0x00 (wrap).
- STOP after 5 data bits -> no wr_valid. Reset asserted while driving a 0 read bit -> sda_oe=0 on the next edge, state IDLE.

Source files
------------

// File: rtl/i2c_cfg_target.sv
// i2c_cfg_target: I2C target that models the HDMI transmitter's configuration
// port. SCL/SDA are oversampled on clk_ref, bus events are decoded, and written
// bytes land in a 256x8 register file that can also be read back over I2C.
//
// Ports:
//   clk_ref   in   reference clock (sole clock, >= 20x SCL)
//   reset     in   synchronous active-high reset
//   scl_in    in   bus SCL (asynchronous)
//   sda_in    in   bus SDA (asynchronous)
//   sda_oe    out  1 = pull SDA low, 0 = release
//   wr_valid  out  one-cycle pulse per committed data byte
//   wr_reg    out  register index of committed byte
//   wr_data   out  committed byte
//   busy      out  high from START to STOP while addressed
//   dbg_reg   in   register-file inspection index
//   dbg_data  out  regs[dbg_reg], 1-cycle latency
module i2c_cfg_target #(
  parameter logic [6:0] DEV_ADDR  = 7'h39,
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic       clk_ref,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] dbg_reg,
  output logic [7:0] dbg_data
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t      state, state_d;
  logic [2:0]  scl_pipe, sda_pipe;   // [0],[1] sync, [2] previous stage
  logic [3:0]  cnt, cnt_d;           // SCL rising edges seen in current byte
  logic [7:0]  sh, sh_d;
  logic [7:0]  ptr, ptr_d;
  logic        sda_oe_d, busy_d;
  logic        rw, rw_d;             // R/W bit of the matched address
  logic        ack, ack_d;           // master ACK/NACK during a read
  logic        commit;
  logic [7:0]  regs [256];
  logic [7:0]  rd_idx, rd_byte;

  wire scl_s     = scl_pipe[1];
  wire sda_s     = sda_pipe[1];
  wire scl_rise  = scl_s & ~scl_pipe[2];
  wire scl_fall  = ~scl_s & scl_pipe[2];
  wire bus_start = scl_s & scl_pipe[2] & ~sda_s & sda_pipe[2];
  wire bus_stop  = scl_s & scl_pipe[2] & sda_s & ~sda_pipe[2];

  // After a master ACK the next byte comes from the incremented pointer.
  assign rd_idx  = (state == RDATA_ACK) ? ptr + 8'd1 : ptr;
  assign rd_byte = regs[rd_idx];

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      scl_pipe <= 3'b111;
      sda_pipe <= 3'b111;
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
      ack      <= 1'b0;
    end else begin
      scl_pipe <= {scl_pipe[1:0], scl_in};
      sda_pipe <= {sda_pipe[1:0], sda_in};
      state    <= state_d;
      cnt      <= cnt_d;
      sh       <= sh_d;
      ptr      <= ptr_d;
      sda_oe   <= sda_oe_d;
      busy     <= busy_d;
      rw       <= rw_d;
      ack      <= ack_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sh_d     = sh;
    ptr_d    = ptr;
    sda_oe_d = sda_oe;
    busy_d   = busy;
    rw_d     = rw;
    ack_d    = ack;
    commit   = 1'b0;
    if (bus_stop) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (bus_start) begin
      state_d = ADDR;
      cnt_d   = '0;
    end else begin
      case (state)
        ADDR, REG, WDATA: begin
          if (scl_rise && cnt < 4'd8) begin
            sh_d  = {sh[6:0], sda_s};
            cnt_d = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_d = '0;
            if (state == ADDR) begin
              if (sh[7:1] == DEV_ADDR) begin
                state_d  = ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = sh[0];
              end else begin
                state_d  = IGNORE;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
              end
            end else if (state == REG) begin
              ptr_d    = sh;
              state_d  = REG_ACK;
              sda_oe_d = 1'b1;
            end else begin
              commit   = 1'b1;
              ptr_d    = ptr + 8'd1;
              state_d  = WDATA_ACK;
              sda_oe_d = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              // First read bit goes out on the same falling edge that ends the ACK.
              state_d  = RDATA;
              sh_d     = {rd_byte[6:0], 1'b0};
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = REG;
              sda_oe_d = 1'b0;
            end
          end
        end
        REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_d  = WDATA;
            sda_oe_d = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise && cnt < 4'd8) begin
            cnt_d = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              state_d  = RDATA_ACK;
              sda_oe_d = 1'b0;
              cnt_d    = '0;
            end else if (cnt != 4'd0) begin
              sda_oe_d = ~sh[7];
              sh_d     = {sh[6:0], 1'b0};
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            ack_d = sda_s;
          end else if (scl_fall) begin
            ptr_d = ptr + 8'd1;
            if (!ack) begin
              state_d  = RDATA;
              sh_d     = {rd_byte[6:0], 1'b0};
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  // Register file, commit strobe and debug port.
  always_ff @(posedge clk_ref) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) regs[i] <= REG_RESET;
      wr_valid <= 1'b0;
      wr_reg   <= '0;
      wr_data  <= '0;
      dbg_data <= REG_RESET;
    end else begin
      wr_valid <= commit;
      if (commit) begin
        regs[ptr] <= sh;
        wr_reg    <= ptr;
        wr_data   <= sh;
      end
      dbg_data <= regs[dbg_reg];
    end
  end

endmodule

// File: tb/tb_i2c_cfg_target.sv
module tb_i2c_cfg_target;

  localparam int Q = 10;  // clk_ref cycles per quarter SCL period

  logic       clk_ref = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_oe;
  logic       wr_valid;
  logic [7:0] wr_reg, wr_data;
  logic       busy;
  logic [7:0] dbg_reg;
  logic [7:0] dbg_data;
  wire        sda_bus = sda_m & ~sda_oe;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic oe_seen, busy_seen;

  i2c_cfg_target dut (
    .clk_ref(clk_ref), .reset(reset), .scl_in(scl), .sda_in(sda_bus),
    .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data),
    .busy(busy), .dbg_reg(dbg_reg), .dbg_data(dbg_data)
  );

  always #10 clk_ref = ~clk_ref;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every commit strobe must match the oldest expected write.
  always @(negedge clk_ref) begin
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (wr_valid) begin
      chk("wr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("wr_event", {wr_reg, wr_data}, exp_q.pop_front());
    end
  end

  task automatic qwait();
    repeat (Q) @(posedge clk_ref);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl = 1'b1;   qwait();
    sda_m = 1'b0; qwait();
    scl = 1'b0;   qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl = 1'b1;   qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m = b;  qwait();
    scl = 1'b1; qwait();
    s = sda_bus; qwait();
    scl = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, a);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    send_bit(nack, s);
  endtask

  task automatic dbg_chk(input string tag, input logic [7:0] idx, input logic [7:0] exp);
    dbg_reg = idx;
    repeat (2) @(posedge clk_ref);
    @(negedge clk_ref);
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic a;
    logic [7:0] rb;
    reset = 1'b1; scl = 1'b1; sda_m = 1'b1; dbg_reg = 8'h00;
    repeat (4) @(posedge clk_ref);
    @(negedge clk_ref);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dbg", dbg_data, 8'h00);
    @(posedge clk_ref); reset = 1'b0;
    repeat (4) @(posedge clk_ref);

    // single write 0x41 <= 0x10
    i2c_start();
    write_byte(8'h72, a); chk("s1_ack_addr", a, 0);
    chk("s1_busy", busy, 1);
    write_byte(8'h41, a); chk("s1_ack_reg", a, 0);
    exp_q.push_back(16'h4110);
    write_byte(8'h10, a); chk("s1_ack_data", a, 0);
    i2c_stop(); qwait();
    chk("s1_busy_after_stop", busy, 0);
    dbg_chk("s1_dbg41", 8'h41, 8'h10);

    // burst write with auto-increment
    i2c_start();
    write_byte(8'h72, a); write_byte(8'h98, a);
    exp_q.push_back(16'h9803); write_byte(8'h03, a);
    exp_q.push_back(16'h99E0); write_byte(8'hE0, a);
    chk("s2_ack_last", a, 0);
    i2c_stop(); qwait();
    dbg_chk("s2_dbg99", 8'h99, 8'hE0);

    // wrong address: fully ignored
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    write_byte(8'h70, a); chk("s3_nack_addr", a, 1);
    write_byte(8'h41, a); chk("s3_nack_reg", a, 1);
    write_byte(8'h55, a);
    i2c_stop(); qwait();
    chk("s3_oe_never", oe_seen, 0);
    chk("s3_busy_never", busy_seen, 0);
    dbg_chk("s3_dbg41", 8'h41, 8'h10);

    // pointer set, repeated start, read two bytes
    i2c_start();
    write_byte(8'h72, a); write_byte(8'h41, a);
    i2c_start();
    write_byte(8'h73, a); chk("s4_ack_raddr", a, 0);
    read_byte(1'b0, rb); chk("s4_rd0", rb, 8'h10);
    read_byte(1'b1, rb); chk("s4_rd1", rb, 8'h00);
    qwait();
    chk("s4_released", sda_oe, 0);
    i2c_stop(); qwait();

    // pointer wrap
    i2c_start();
    write_byte(8'h72, a); write_byte(8'hFF, a);
    exp_q.push_back(16'hFFAA); write_byte(8'hAA, a);
    exp_q.push_back(16'h00BB); write_byte(8'hBB, a);
    i2c_stop(); qwait();
    dbg_chk("s5_dbgFF", 8'hFF, 8'hAA);
    dbg_chk("s5_dbg00", 8'h00, 8'hBB);

    // STOP after 5 data bits: no commit
    i2c_start();
    write_byte(8'h72, a); write_byte(8'h20, a);
    for (int i = 7; i >= 3; i--) begin
      logic s;
      rb = 8'h5A;
      send_bit(rb[i], s);
    end
    i2c_stop(); qwait();
    dbg_chk("s6_dbg20", 8'h20, 8'h00);

    // reset while driving a 0 read bit
    i2c_start();
    write_byte(8'h72, a); write_byte(8'h60, a);
    i2c_stop(); qwait();
    i2c_start();
    write_byte(8'h73, a);
    qwait();
    chk("s7_driving", sda_oe, 1);
    @(posedge clk_ref); reset = 1'b1;
    @(posedge clk_ref); #1;
    chk("s7_rst_release", sda_oe, 0);
    chk("s7_rst_busy", busy, 0);
    reset = 1'b0;
    scl = 1'b1; sda_m = 1'b1;
    repeat (8) @(posedge clk_ref);
    dbg_chk("s7_regs_reset", 8'h41, 8'h00);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
